// File: rtl/alarm_match_seq_pkg.sv
// Shared definitions for the alarm-match controller: scan/ring state
// encoding, default field width and default ring duration.
package alarm_match_seq_pkg;

  localparam int unsigned FIELD_W      = 6;
  localparam int unsigned RING_SEC_DEF = 60;
  localparam int unsigned RING_CNT_W   = 6;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    S_SEC  = 3'd1,
    S_MIN  = 3'd2,
    S_HOUR = 3'd3,
    RING   = 3'd4
  } state_e;

  // True while the shared comparator is being driven by this block.
  function automatic logic is_scan_state(input state_e s);
    return (s == S_SEC) || (s == S_MIN) || (s == S_HOUR);
  endfunction

endpackage

// File: rtl/alarm_match_seq_ring_cnt.sv
// Loadable down-counter holding the remaining ring time in ticks.
// Priority: clear over load over decrement; never wraps below zero.
module alarm_match_seq_ring_cnt #(
  parameter int unsigned CNT_W    = 6,
  parameter int unsigned LOAD_VAL = 60
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             is_zero,
  output logic             is_one
);

  localparam logic [CNT_W-1:0] LOAD_V = CNT_W'(LOAD_VAL);
  localparam logic [CNT_W-1:0] ONE_V  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear, reload, or step down one tick.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = LOAD_V;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE_V;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign is_zero = (cnt_q == '0);
  assign is_one  = (cnt_q == ONE_V);

endmodule

// File: rtl/alarm_match_seq.sv
// Alarm-match controller: on a tick, snapshots current and alarm time and
// walks seconds, minutes, hours through one shared external comparator,
// bailing out on the first mismatch. A full match rings for RING_SEC ticks.
module alarm_match_seq
  import alarm_match_seq_pkg::*;
#(
  parameter int unsigned W        = FIELD_W,
  parameter int unsigned RING_SEC = RING_SEC_DEF,
  parameter int unsigned CNT_W    = RING_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             alarm_en,
  input  logic             stop,
  input  logic [W-1:0]     cur_sec,
  input  logic [W-1:0]     cur_min,
  input  logic [W-1:0]     cur_hour,
  input  logic [W-1:0]     alm_sec,
  input  logic [W-1:0]     alm_min,
  input  logic [W-1:0]     alm_hour,
  output logic [W-1:0]     cmp_a,
  output logic [W-1:0]     cmp_b,
  output logic             cmp_en,
  input  logic             cmp_eq,
  output logic             busy,
  output logic             match_p,
  output logic             alarm_ring,
  output logic [CNT_W-1:0] ring_left
);

  state_e state_q;
  state_e state_d;

  logic [W-1:0] snap_cur_sec_q, snap_cur_min_q, snap_cur_hour_q;
  logic [W-1:0] snap_alm_sec_q, snap_alm_min_q, snap_alm_hour_q;
  logic [W-1:0] snap_cur_sec_d, snap_cur_min_d, snap_cur_hour_d;
  logic [W-1:0] snap_alm_sec_d, snap_alm_min_d, snap_alm_hour_d;

  logic match_p_q, match_p_d;
  logic alarm_ring_q, alarm_ring_d;

  logic snap_load;
  logic ring_load;
  logic ring_dec;
  logic ring_clr;
  logic ring_is_zero;
  logic ring_is_one;

  alarm_match_seq_ring_cnt #(
    .CNT_W    (CNT_W),
    .LOAD_VAL (RING_SEC)
  ) u_ring_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (ring_load),
    .dec     (ring_dec),
    .clr     (ring_clr),
    .cnt     (ring_left),
    .is_zero (ring_is_zero),
    .is_one  (ring_is_one)
  );

  // Next-state and control: disable beats everything, stop beats tick in RING.
  always_comb begin
    state_d   = state_q;
    snap_load = 1'b0;
    ring_load = 1'b0;
    ring_dec  = 1'b0;
    ring_clr  = 1'b0;
    match_p_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick && alarm_en) begin
          state_d   = S_SEC;
          snap_load = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      S_SEC: begin
        if (!alarm_en) begin
          state_d  = IDLE;
          ring_clr = 1'b1;
        end else if (cmp_eq) begin
          state_d = S_MIN;
        end else begin
          state_d = IDLE;
        end
      end
      S_MIN: begin
        if (!alarm_en) begin
          state_d  = IDLE;
          ring_clr = 1'b1;
        end else if (cmp_eq) begin
          state_d = S_HOUR;
        end else begin
          state_d = IDLE;
        end
      end
      S_HOUR: begin
        if (!alarm_en) begin
          state_d  = IDLE;
          ring_clr = 1'b1;
        end else if (cmp_eq) begin
          state_d   = RING;
          ring_load = 1'b1;
          match_p_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RING: begin
        if (!alarm_en || stop) begin
          state_d  = IDLE;
          ring_clr = 1'b1;
        end else if (tick) begin
          ring_dec = 1'b1;
          if (ring_is_one || ring_is_zero) begin
            state_d = IDLE;
          end else begin
            state_d = RING;
          end
        end else begin
          state_d = RING;
        end
      end
      default: begin
        state_d  = IDLE;
        ring_clr = 1'b1;
      end
    endcase
    alarm_ring_d = (state_d == RING);
  end

  // Snapshot capture so mid-scan time changes cannot disturb a scan.
  always_comb begin
    if (snap_load) begin
      snap_cur_sec_d  = cur_sec;
      snap_cur_min_d  = cur_min;
      snap_cur_hour_d = cur_hour;
      snap_alm_sec_d  = alm_sec;
      snap_alm_min_d  = alm_min;
      snap_alm_hour_d = alm_hour;
    end else begin
      snap_cur_sec_d  = snap_cur_sec_q;
      snap_cur_min_d  = snap_cur_min_q;
      snap_cur_hour_d = snap_cur_hour_q;
      snap_alm_sec_d  = snap_alm_sec_q;
      snap_alm_min_d  = snap_alm_min_q;
      snap_alm_hour_d = snap_alm_hour_q;
    end
  end

  // State, snapshot and registered output flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      snap_cur_sec_q  <= '0;
      snap_cur_min_q  <= '0;
      snap_cur_hour_q <= '0;
      snap_alm_sec_q  <= '0;
      snap_alm_min_q  <= '0;
      snap_alm_hour_q <= '0;
      match_p_q       <= 1'b0;
      alarm_ring_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      snap_cur_sec_q  <= snap_cur_sec_d;
      snap_cur_min_q  <= snap_cur_min_d;
      snap_cur_hour_q <= snap_cur_hour_d;
      snap_alm_sec_q  <= snap_alm_sec_d;
      snap_alm_min_q  <= snap_alm_min_d;
      snap_alm_hour_q <= snap_alm_hour_d;
      match_p_q       <= match_p_d;
      alarm_ring_q    <= alarm_ring_d;
    end
  end

  // Operand mux onto the shared comparator; quiet outside the scan states.
  always_comb begin
    cmp_a  = '0;
    cmp_b  = '0;
    cmp_en = 1'b0;
    case (state_q)
      S_SEC: begin
        cmp_a  = snap_cur_sec_q;
        cmp_b  = snap_alm_sec_q;
        cmp_en = 1'b1;
      end
      S_MIN: begin
        cmp_a  = snap_cur_min_q;
        cmp_b  = snap_alm_min_q;
        cmp_en = 1'b1;
      end
      S_HOUR: begin
        cmp_a  = snap_cur_hour_q;
        cmp_b  = snap_alm_hour_q;
        cmp_en = 1'b1;
      end
      default: begin
        cmp_a  = '0;
        cmp_b  = '0;
        cmp_en = 1'b0;
      end
    endcase
  end

  assign busy       = is_scan_state(state_q);
  assign match_p    = match_p_q;
  assign alarm_ring = alarm_ring_q;

endmodule
